overlap_add_engine: RTL and testbench
=====================================

# overlap_add_engine

Streaming, multi-channel successor to the parallel overlap/add controller. Consumes IMDCT output one sample per cycle (2·halfWindowSize samples per frame). For each frame it adds the first half to the stored second half of the previous frame of the same channel, saturates the sum, and emits it over a valid/ready stream. The second half is held in a per-channel overlap buffer. Sits between the IMDCT/windowing stage and the PCM output formatter.

## Interface
- halfWindowSize, 512, samples per half window (N); power of two
- wordLength, 16, signed sample width (W)
- numChannels, 2, independent overlap channels (C ≥ 1)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_data  in  W  signed IMDCT sample
- in_valid  in  1  in_data valid
- in_ready  out  1  sample accepted when in_valid & in_ready
- in_frameStart  in  1  marks sample 0 of a frame
- in_seqPos  in  2  0 = middle, 1 = first, 2 = last, 3 = reserved; sampled with in_frameStart
- in_chan  in  max(1,clog2(C))  channel; sampled with in_frameStart
- out_data  out  W  saturated PCM sample
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_chan  out  max(1,clog2(C))  channel of out_data
- out_last  out  1  last output sample of the frame
- seqErr  out  1  one-cycle pulse: reserved in_seqPos seen
- frameErr  out  1  one-cycle pulse: frame protocol violation

## Operation
- States: IDLE, FIRST_HALF, SECOND_HALF; sample counter idx spans 0..N-1 per half.
- IDLE: a sample accepted with in_frameStart=1 latches seqPos and chan, processes as idx 0 → FIRST_HALF. A sample accepted with in_frameStart=0 is dropped and pulses frameErr.
- FIRST_HALF output: mode first → in; mode middle or last → sat(in + buf[chan][idx]). buf reads as 0 if the channel's primed bit is clear. idx=N-1 → SECOND_HALF.
- SECOND_HALF: mode middle/first → write buf[chan][idx] = in, no output; at idx=N-1 set primed[chan] and go to IDLE. Mode last → output in directly, no buffer write; at idx=N-1 clear primed[chan] and go to IDLE.
- Reserved seqPos (3): processed as middle; seqErr pulses on the frameStart sample.
- in_frameStart=1 while not in IDLE: frameErr pulses, the current frame is abandoned, and the sample starts a new frame. Buffer entries already written stay written; primed is unchanged.
- Saturation: form the sum at W+1 bits; clamp to [-2^(W-1), 2^(W-1)-1].
- out_last = 1 on FIRST_HALF idx N-1 for middle/first frames, and on SECOND_HALF idx N-1 for last frames.
- Buffer contents are not reset. Reset clears all primed bits, so the first frame per channel after reset overlaps with zero.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, out_last=0, seqErr=0, frameErr=0; state IDLE, idx=0, primed all 0.
- in_ready = !out_valid | out_ready, with one exception: in_ready = 1 in SECOND_HALF of middle/first frames, because no output is produced.
- Latency: accepted sample → out_valid on the next cycle. Throughput is 1 sample/cycle under continuous out_ready.
- out_valid holds with stable out_data, out_chan and out_last until out_ready.
- Buffer read is combinational on {chan, idx}. A buffer write commits at the clock edge of acceptance.
- rst_n low mid-frame: everything returns to reset values on that edge, and any pending output is discarded.

## Structure
- Shared package overlap_pkg: the seqPos encoding localparams (SEQ_MIDDLE, SEQ_FIRST, SEQ_LAST), the state encoding, and the saturating-add function.
- Sub-module overlap_buffer: a C·N × W array with one combinational read port and one synchronous write port. It holds no reset.
- Top level holds the FSM, counter, primed bits, adder/saturator and output register. Target 200–300 lines.

## Test plan
- N=4, W=16, C=1. Frame first {1,2,3,4,10,20,30,40}, then middle {5,5,5,5,…} → outputs {1,2,3,4} then {15,25,35,45}.
- Saturation. Buffer holds 32000; middle frame sample 1000 → 32767. Buffer −32000 with sample −1000 → −32768.
- C=2, interleaved frames on channels 0 and 1 → each channel overlaps only its own data. A middle frame right after reset → output equals input (buf reads as 0).
- Mode last {1,1,1,1,7,8,9,10} after buffer {2,2,2,2} → 8 outputs {3,3,3,3,7,8,9,10}, out_last on the 8th. A following middle frame → overlaps with 0.
- Backpressure: hold out_ready=0 for 5 cycles mid FIRST_HALF → in_ready=0, out_data stable, no sample lost or duplicated.
- in_frameStart at idx 2 of FIRST_HALF → frameErr pulse, new frame restarts at idx 0. in_seqPos=3 → seqErr pulse and middle behaviour.

Source files
------------

// File: rtl/overlap_add_engine_pkg.sv
// Shared definitions for the overlap/add engine: sequence-position codes,
// FSM states and the saturating adder.
package overlap_pkg;

  localparam logic [1:0] SEQ_MIDDLE = 2'd0;
  localparam logic [1:0] SEQ_FIRST  = 2'd1;
  localparam logic [1:0] SEQ_LAST   = 2'd2;
  localparam logic [1:0] SEQ_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FIRST_HALF  = 2'd1,
    SECOND_HALF = 2'd2
  } state_t;

  // Operands arrive sign-extended to 32 bits; the result is clamped to a
  // signed w-bit range (w <= 32) and returned sign-extended.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = {a[31], a} + {b[31], b};
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi)      return hi[31:0];
    else if (s < lo) return lo[31:0];
    else             return s[31:0];
  endfunction

endpackage

// File: rtl/overlap_add_engine_if.sv
// Sample-in / PCM-out stream bundle for the overlap/add engine.
interface overlap_add_engine_if #(
  parameter int unsigned wordLength = 16,
  parameter int unsigned chanWidth  = 1
) ();
  logic [wordLength-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_frameStart;
  logic [1:0]            in_seqPos;
  logic [chanWidth-1:0]  in_chan;
  logic [wordLength-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [chanWidth-1:0]  out_chan;
  logic                  out_last;
  logic                  seqErr;
  logic                  frameErr;

  modport master (
    output in_data, in_valid, in_frameStart, in_seqPos, in_chan, out_ready,
    input  in_ready, out_data, out_valid, out_chan, out_last, seqErr, frameErr
  );

  modport slave (
    input  in_data, in_valid, in_frameStart, in_seqPos, in_chan, out_ready,
    output in_ready, out_data, out_valid, out_chan, out_last, seqErr, frameErr
  );
endinterface

// File: rtl/overlap_add_engine_buffer.sv
// Per-channel overlap store: combinational read, synchronous write, no reset.
module overlap_buffer #(
  parameter int unsigned depth      = 1024,
  parameter int unsigned wordLength = 16,
  parameter int unsigned addrWidth  = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addrWidth-1:0]  waddr,
  input  logic [wordLength-1:0] wdata,
  input  logic [addrWidth-1:0]  raddr,
  output logic [wordLength-1:0] rdata
);

  logic [wordLength-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/overlap_add_engine.sv
// Streaming multi-channel overlap/add: first half of each frame is added to the
// stored second half of the previous frame on the same channel, saturated, emitted.
module overlap_add_engine
  import overlap_pkg::*;
#(
  parameter int unsigned halfWindowSize = 512,
  parameter int unsigned wordLength     = 16,
  parameter int unsigned numChannels    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  overlap_add_engine_if.slave   bus
);

  localparam int unsigned N  = halfWindowSize;
  localparam int unsigned W  = wordLength;
  localparam int unsigned C  = numChannels;
  localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = (C * N > 1) ? $clog2(C * N) : 1;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [1:0]      mode_q, mode_d;
  logic [CW-1:0]   chan_q, chan_d;
  logic [C-1:0]    primed_q, primed_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [CW-1:0]   out_chan_q, out_chan_d;
  logic            out_last_q, out_last_d;
  logic            seq_err_q, seq_err_d;
  logic            frame_err_q, frame_err_d;

  logic            in_ready_c;
  logic            accept;
  logic            start;
  logic [1:0]      eff_mode;
  logic [CW-1:0]   eff_chan;
  logic [IW-1:0]   eff_idx;
  logic            eff_second;
  logic            end_of_half;
  logic [AW-1:0]   buf_addr;
  logic [W-1:0]    buf_rdata;
  logic [W-1:0]    ovl;
  logic [W-1:0]    sum;
  logic            buf_we;

  overlap_buffer #(
    .depth      (C * N),
    .wordLength (W),
    .addrWidth  (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_addr),
    .wdata (bus.in_data),
    .raddr (buf_addr),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    chan_d      = chan_q;
    primed_d    = primed_q;
    out_valid_d = out_valid_q & ~bus.out_ready;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_last_d  = out_last_q;
    seq_err_d   = 1'b0;
    frame_err_d = 1'b0;
    buf_we      = 1'b0;

    // Second half of a non-last frame produces no output, so it never stalls.
    in_ready_c = ~out_valid_q | bus.out_ready;
    if (state_q == SECOND_HALF && mode_q != SEQ_LAST) in_ready_c = 1'b1;

    accept = bus.in_valid & in_ready_c;
    start  = accept & bus.in_frameStart;

    // A frameStart sample restarts at idx 0 of the first half in any state.
    eff_mode   = mode_q;
    eff_chan   = chan_q;
    eff_idx    = idx_q;
    eff_second = (state_q == SECOND_HALF);
    if (start) begin
      eff_mode   = bus.in_seqPos;
      eff_chan   = bus.in_chan;
      eff_idx    = '0;
      eff_second = 1'b0;
    end

    end_of_half = (eff_idx == IW'(N - 1));
    buf_addr    = AW'(eff_chan * N + eff_idx);
    ovl         = primed_q[eff_chan] ? buf_rdata : '0;
    sum         = W'(sat_add(32'(signed'(bus.in_data)), 32'(signed'(ovl)), W));

    if (accept) begin
      if (state_q == IDLE && !bus.in_frameStart) begin
        frame_err_d = 1'b1;
      end else begin
        if (start) begin
          frame_err_d = (state_q != IDLE);
          seq_err_d   = (bus.in_seqPos == SEQ_RSVD);
          mode_d      = bus.in_seqPos;
          chan_d      = bus.in_chan;
        end
        idx_d = end_of_half ? '0 : eff_idx + IW'(1);
        if (!eff_second) begin
          out_valid_d = 1'b1;
          out_data_d  = (eff_mode == SEQ_FIRST) ? bus.in_data : sum;
          out_chan_d  = eff_chan;
          out_last_d  = end_of_half && (eff_mode != SEQ_LAST);
          state_d     = end_of_half ? SECOND_HALF : FIRST_HALF;
        end else if (eff_mode == SEQ_LAST) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.in_data;
          out_chan_d  = eff_chan;
          out_last_d  = end_of_half;
          if (end_of_half) primed_d[eff_chan] = 1'b0;
          state_d     = end_of_half ? IDLE : SECOND_HALF;
        end else begin
          buf_we = 1'b1;
          if (end_of_half) primed_d[eff_chan] = 1'b1;
          state_d = end_of_half ? IDLE : SECOND_HALF;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      mode_q      <= SEQ_MIDDLE;
      chan_q      <= '0;
      primed_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_last_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      chan_q      <= chan_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_last_q  <= out_last_d;
      seq_err_q   <= seq_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_last  = out_last_q;
  assign bus.seqErr    = seq_err_q;
  assign bus.frameErr  = frame_err_q;

endmodule

// File: tb/tb_overlap_add_engine.sv
// Directed bench for overlap_add_engine with N=4, W=16, C=2.
module tb_overlap_add_engine;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  overlap_add_engine_if #(.wordLength(16), .chanWidth(1)) bus ();

  overlap_add_engine #(
    .halfWindowSize (4),
    .wordLength     (16),
    .numChannels    (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [15:0] din;
    logic        fs;
    logic [1:0]  seq;
    logic        ch;
    logic        ev;
    logic [15:0] ed;
    logic        el;
    logic        ese;
    logic        efe;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic addv(input int d, input bit fs, input int seq, input int ch,
                      input bit ev, input int ed, input bit el, input bit se, input bit fe);
    vec_t v;
    v.din = 16'(d);  v.fs = fs;  v.seq = 2'(seq);  v.ch = 1'(ch);
    v.ev  = ev;      v.ed = 16'(ed);  v.el = el;   v.ese = se;  v.efe = fe;
    vecs.push_back(v);
  endtask

  // Emitting sample: first-half or last-frame sample with expected output.
  task automatic em(input int d, input bit fs, input int seq, input int ch,
                    input int ed, input bit el);
    addv(d, fs, seq, ch, 1'b1, ed, el, 1'b0, 1'b0);
  endtask

  // Silent sample: second half of a middle/first frame.
  task automatic sl(input int d, input int ch);
    addv(d, 1'b0, 0, ch, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive(input int d, input bit fs, input int seq, input int ch);
    bus.in_data       = 16'(d);
    bus.in_frameStart = fs;
    bus.in_seqPos     = 2'(seq);
    bus.in_chan       = 1'(ch);
    bus.in_valid      = 1'b1;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.in_data       = '0;
    bus.in_valid      = 1'b0;
    bus.in_frameStart = 1'b0;
    bus.in_seqPos     = '0;
    bus.in_chan       = '0;
    bus.out_ready     = 1'b1;

    // Stray sample in IDLE: dropped with frameErr
    addv(99, 0, 0, 0, 0, 0, 0, 0, 1);
    // ch0 first frame
    em(1, 1, 1, 0, 1, 0); em(2, 0, 0, 0, 2, 0); em(3, 0, 0, 0, 3, 0); em(4, 0, 0, 0, 4, 1);
    sl(10, 0); sl(20, 0); sl(30, 0); sl(40, 0);
    // ch1 middle right after reset: overlaps with zero
    em(100, 1, 0, 1, 100, 0); em(200, 0, 0, 1, 200, 0); em(300, 0, 0, 1, 300, 0); em(400, 0, 0, 1, 400, 1);
    sl(7, 1); sl(8, 1); sl(9, 1); sl(-6, 1);
    // ch0 middle
    em(5, 1, 0, 0, 15, 0); em(5, 0, 0, 0, 25, 0); em(5, 0, 0, 0, 35, 0); em(5, 0, 0, 0, 45, 1);
    sl(32000, 0); sl(-32000, 0); sl(0, 0); sl(0, 0);
    // ch1 middle: own channel data only
    em(1, 1, 0, 1, 8, 0); em(1, 0, 0, 1, 9, 0); em(1, 0, 0, 1, 10, 0); em(1, 0, 0, 1, -5, 1);
    sl(2, 1); sl(2, 1); sl(2, 1); sl(2, 1);
    // ch0 saturation both directions
    em(1000, 1, 0, 0, 32767, 0); em(-1000, 0, 0, 0, -32768, 0); em(3, 0, 0, 0, 3, 0); em(4, 0, 0, 0, 4, 1);
    sl(0, 0); sl(0, 0); sl(0, 0); sl(0, 0);
    // ch1 last frame: 8 outputs, out_last on the 8th
    em(1, 1, 2, 1, 3, 0); em(1, 0, 0, 1, 3, 0); em(1, 0, 0, 1, 3, 0); em(1, 0, 0, 1, 3, 0);
    em(7, 0, 0, 1, 7, 0); em(8, 0, 0, 1, 8, 0); em(9, 0, 0, 1, 9, 0); em(10, 0, 0, 1, 10, 1);
    // ch1 middle after last: overlaps with zero
    em(4, 1, 0, 1, 4, 0); em(4, 0, 0, 1, 4, 0); em(4, 0, 0, 1, 4, 0); em(4, 0, 0, 1, 4, 1);
    sl(11, 1); sl(12, 1); sl(13, 1); sl(14, 1);
    // ch0 reserved seqPos: seqErr and middle behaviour (buffer holds zeros)
    addv(6, 1, 3, 0, 1, 6, 0, 1, 0); em(7, 0, 0, 0, 7, 0); em(8, 0, 0, 0, 8, 0); em(9, 0, 0, 0, 9, 1);
    sl(21, 0); sl(22, 0); sl(23, 0); sl(24, 0);
    // ch1 frame restarted at idx 2: frameErr, new frame begins at idx 0
    em(1, 1, 0, 1, 12, 0); em(1, 0, 0, 1, 13, 0);
    addv(2, 1, 0, 1, 1, 13, 0, 0, 1);
    em(2, 0, 0, 1, 14, 0); em(2, 0, 0, 1, 15, 0); em(2, 0, 0, 1, 16, 1);
    sl(0, 1); sl(0, 1); sl(0, 1); sl(0, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_chan",  32'(bus.out_chan),  32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_seqErr",    32'(bus.seqErr),    32'd0);
    chk("rst_frameErr",  32'(bus.frameErr),  32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(int'(vecs[i].din), vecs[i].fs, int'(vecs[i].seq), int'(vecs[i].ch));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_data", i), 32'(bus.out_data), 32'(vecs[i].ed));
        chk($sformatf("v%0d_chan", i), 32'(bus.out_chan), 32'(vecs[i].ch));
        chk($sformatf("v%0d_last", i), 32'(bus.out_last), 32'(vecs[i].el));
      end
      chk($sformatf("v%0d_seqErr", i),   32'(bus.seqErr),   32'(vecs[i].ese));
      chk($sformatf("v%0d_frameErr", i), 32'(bus.frameErr), 32'(vecs[i].efe));
    end
    bus.in_valid = 1'b0;

    // Backpressure on ch0 middle frame; buffer holds {21,22,23,24}
    drive(1, 1, 0, 0);
    @(posedge clk); #1;
    chk("bp_s0_data", 32'(bus.out_data), 32'd22);
    drive(2, 0, 0, 0);
    @(posedge clk); #1;
    chk("bp_s1_data", 32'(bus.out_data), 32'd24);
    bus.out_ready = 1'b0;
    drive(3, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_stall%0d_in_ready", k), 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("bp_stall%0d_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp_stall%0d_data", k),  32'(bus.out_data),  32'd24);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_s2_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_s2_data",  32'(bus.out_data),  32'd26);
    drive(4, 0, 0, 0);
    @(posedge clk); #1;
    chk("bp_s3_data", 32'(bus.out_data), 32'd28);
    chk("bp_s3_last", 32'(bus.out_last), 32'd1);

    // Second half keeps accepting while the last output is stalled
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0);
      #1;
      chk($sformatf("bp_h2_%0d_in_ready", k), 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("bp_h2_%0d_data", k), 32'(bus.out_data), 32'd28);
    end
    bus.in_valid = 1'b0;
    #1;
    chk("bp_idle_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drain_valid", 32'(bus.out_valid), 32'd0);

    // Second-half writes under stall landed: ch0 now overlaps with zero
    drive(5, 1, 0, 0);
    @(posedge clk); #1;
    chk("bp_after_data", 32'(bus.out_data), 32'd5);
    bus.in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
